// File: rtl/div_share_arb_pkg.sv
// Shared constants, types and helpers for the shared-divider arbiter.
// Optional feature macro: DIV_SHARE_ARB_ZERO_CHECK_EN (divide-by-zero detection).
package div_share_arb_pkg;

  localparam int unsigned DEF_W     = 16;
  localparam int unsigned DEF_N_REQ = 4;

  // Pipeline entries are sized for the widest supported build; narrower
  // builds zero-extend on entry and truncate on exit.
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_TAG_W = 8;

  // Quotient reported for a zero divisor when detection is enabled.
  localparam logic [MAX_W-1:0] DZ_ALL_ONES = '1;

  // Requester tag width: clog2 of the requester count, at least one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_W-1:0]     quot;
    logic [MAX_W-1:0]     rem;
    logic                 dz;
  } pipe_entry_t;

endpackage

// File: rtl/div_share_arb_div_comb.sv
// Combinational unsigned divider shared by all requesters.
module div_comb #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] numer_i,
  input  logic [W-1:0] denom_i,
  output logic [W-1:0] quot_c_o,
  output logic [W-1:0] rem_c_o
);

  assign quot_c_o = numer_i / denom_i;
  assign rem_c_o  = numer_i % denom_i;

endmodule

// File: rtl/div_share_arb_rr_arbiter.sv
// Round-robin grant: search starts one past the last granted index.
module div_rr_arbiter
  import div_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_c_o
);

  localparam int unsigned TAG_W = tag_w(N_REQ);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;
  logic [TAG_W-1:0] idx_c;
  logic             found_c;

  // Scan from the pointer; the first requesting index wins and moves the pointer past it.
  always_comb begin
    grant_c_o = '0;
    ptr_d     = ptr_q;
    idx_c     = '0;
    found_c   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = TAG_W'((32'(ptr_q) + k) % N_REQ);
      if (!found_c && req_i[idx_c]) begin
        found_c          = 1'b1;
        grant_c_o[idx_c] = 1'b1;
        ptr_d            = (32'(idx_c) == N_REQ - 1) ? '0 : idx_c + TAG_W'(1);
      end
    end
  end

  // Pointer register; search restarts at requester 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/div_share_arb.sv
// Divider shared between N_REQ requesters: round-robin accept, operand stage,
// one combinational divider, DIV_LAT result stages, per-requester held response.
// Optional feature macro: DIV_SHARE_ARB_ZERO_CHECK_EN (zero divisor yields
// all-ones quotient, remainder = dividend, resp_dz = 1).
module div_share_arb
  import div_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DIV_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_numer,
  input  logic [N_REQ*W-1:0] req_denom,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [N_REQ*W-1:0] resp_quot,
  output logic [N_REQ*W-1:0] resp_rem,
  output logic [N_REQ-1:0]   resp_dz,
  output logic               busy
);

  localparam int unsigned TAG_W = tag_w(N_REQ);

  logic [N_REQ-1:0]   elig_c;
  logic [N_REQ-1:0]   grant_c;
  logic [N_REQ-1:0]   inflight_q;
  logic [N_REQ-1:0]   inflight_d;

  logic               op_valid_q;
  logic               op_valid_d;
  logic [TAG_W-1:0]   op_tag_q;
  logic [TAG_W-1:0]   op_tag_d;
  logic [W-1:0]       op_numer_q;
  logic [W-1:0]       op_numer_d;
  logic [W-1:0]       op_denom_q;
  logic [W-1:0]       op_denom_d;

  logic [W-1:0]       div_quot_c;
  logic [W-1:0]       div_rem_c;
  pipe_entry_t        stage_in_c;
  pipe_entry_t        pipe_q [DIV_LAT];
  pipe_entry_t        pipe_d [DIV_LAT];

  logic [N_REQ-1:0]   resp_valid_q;
  logic [N_REQ-1:0]   resp_valid_d;
  logic [N_REQ*W-1:0] resp_quot_q;
  logic [N_REQ*W-1:0] resp_quot_d;
  logic [N_REQ*W-1:0] resp_rem_q;
  logic [N_REQ*W-1:0] resp_rem_d;

  // One outstanding op per requester: idle in the pipe and no held result.
  assign elig_c = req_valid & ~inflight_q & ~resp_valid_q & {N_REQ{rst_n}};

  div_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (elig_c),
    .grant_c_o (grant_c)
  );

  assign req_ready = grant_c;

  // Operand stage capture: the granted requester's operands and tag.
  always_comb begin
    op_valid_d = |grant_c;
    op_tag_d   = op_tag_q;
    op_numer_d = op_numer_q;
    op_denom_d = op_denom_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        op_tag_d   = TAG_W'(i);
        op_numer_d = req_numer[i*W +: W];
        op_denom_d = req_denom[i*W +: W];
      end
    end
  end

  div_comb #(
    .W (W)
  ) u_div (
    .numer_i  (op_numer_q),
    .denom_i  (op_denom_q),
    .quot_c_o (div_quot_c),
    .rem_c_o  (div_rem_c)
  );

  // Build the entry that enters the first result stage.
  always_comb begin
    stage_in_c       = '0;
    stage_in_c.valid = op_valid_q;
    stage_in_c.tag   = MAX_TAG_W'(op_tag_q);
    stage_in_c.quot  = MAX_W'(div_quot_c);
    stage_in_c.rem   = MAX_W'(div_rem_c);
`ifdef DIV_SHARE_ARB_ZERO_CHECK_EN
    if (op_denom_q == '0) begin
      stage_in_c.quot = DZ_ALL_ONES;
      stage_in_c.rem  = MAX_W'(op_numer_q);
      stage_in_c.dz   = 1'b1;
    end
`endif
  end

  // Result stages shift one entry per cycle.
  always_comb begin
    pipe_d[0] = stage_in_c;
    for (int unsigned k = 1; k < DIV_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // Retire the last stage into the tagged requester's response slot.
  always_comb begin
    inflight_d   = inflight_q | grant_c;
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_quot_d  = resp_quot_q;
    resp_rem_d   = resp_rem_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pipe_q[DIV_LAT-1].valid && (pipe_q[DIV_LAT-1].tag == MAX_TAG_W'(i))) begin
        inflight_d[i]         = 1'b0;
        resp_valid_d[i]       = 1'b1;
        resp_quot_d[i*W +: W] = W'(pipe_q[DIV_LAT-1].quot);
        resp_rem_d[i*W +: W]  = W'(pipe_q[DIV_LAT-1].rem);
      end
    end
  end

  // Operand stage, result stages and response slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q   <= 1'b0;
      op_tag_q     <= '0;
      op_numer_q   <= '0;
      op_denom_q   <= '0;
      inflight_q   <= '0;
      resp_valid_q <= '0;
      resp_quot_q  <= '0;
      resp_rem_q   <= '0;
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      op_valid_q   <= op_valid_d;
      op_tag_q     <= op_tag_d;
      op_numer_q   <= op_numer_d;
      op_denom_q   <= op_denom_d;
      inflight_q   <= inflight_d;
      resp_valid_q <= resp_valid_d;
      resp_quot_q  <= resp_quot_d;
      resp_rem_q   <= resp_rem_d;
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

`ifdef DIV_SHARE_ARB_ZERO_CHECK_EN
  logic [N_REQ-1:0] resp_dz_q;
  logic [N_REQ-1:0] resp_dz_d;

  // Zero-divide flag travels with the held result.
  always_comb begin
    resp_dz_d = resp_dz_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pipe_q[DIV_LAT-1].valid && (pipe_q[DIV_LAT-1].tag == MAX_TAG_W'(i))) begin
        resp_dz_d[i] = pipe_q[DIV_LAT-1].dz;
      end
    end
  end

  // Zero-divide flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_dz_q <= '0;
    end else begin
      resp_dz_q <= resp_dz_d;
    end
  end

  assign resp_dz = resp_dz_q;
`else
  assign resp_dz = '0;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_quot  = resp_quot_q;
  assign resp_rem   = resp_rem_q;
  assign busy       = (|inflight_q) | (|resp_valid_q);

endmodule

// File: doc/div_share_arb.md
DIV_SHARE_ARB -- requirements
Module: div_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the divider.
REQ-002 SHALL have parameter W, default 16: operand and result width.
REQ-003 SHALL have parameter DIV_LAT, default 2 (min 1): register stages after the combinational division instance.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester grant.
REQ-008 SHALL have port req_numer  input  N_REQ x W  dividend per requester.
REQ-009 SHALL have port req_denom  input  N_REQ x W  divisor per requester.
REQ-010 SHALL have port resp_valid  output  N_REQ  result held for requester.
REQ-011 SHALL have port resp_ready  input  N_REQ  requester consumes result.
REQ-012 SHALL have port resp_quot  output  N_REQ x W  quotient per requester.
REQ-013 SHALL have port resp_rem  output  N_REQ x W  remainder per requester.
REQ-014 SHALL have port resp_dz  output  N_REQ  divide-by-zero flag per requester.
REQ-015 SHALL have port busy  output  1  high while any operation is in flight or any resp_valid is high.

Function
REQ-016 Eligible requester i: req_valid[i]=1, nothing in flight for i, and resp_valid[i]=0 (one outstanding op per requester).
REQ-017 req_ready SHALL be one-hot or zero and combinational; bit i high only if requester i is eligible.
REQ-018 Arbitration SHALL be round-robin: search begins at (last granted index + 1) mod N_REQ; after reset search begins at 0.
REQ-019 At most one accept (req_valid&req_ready) per cycle; accepts in consecutive cycles SHALL be supported (full throughput).
REQ-020 Accept edge registers numer, denom and requester tag into the operand stage feeding the division instance.
REQ-021 Result plus tag SHALL traverse DIV_LAT registers; resp_valid[tag] rises exactly DIV_LAT+1 edges after the accept edge.
REQ-022 resp_quot/resp_rem/resp_dz[i] SHALL hold stable while resp_valid[i]=1 and SHALL clear it on the edge where resp_ready[i]=1.
REQ-023 Result values: quot = numer / denom, rem = numer mod denom, unsigned W-bit.
REQ-024 Requester i SHALL become eligible in the cycle after its response is consumed (no same-cycle re-grant).
REQ-025 req_ready[i] is not a function of resp_ready[i].

Reset
REQ-026 rst_n low SHALL asynchronously clear req_ready, resp_valid, resp_dz, busy, all pipeline valid bits and the round-robin pointer.
REQ-027 Reset mid-operation SHALL discard all in-flight and held results; none SHALL appear after release.
REQ-028 resp_quot and resp_rem SHALL reset to 0.

Configuration
REQ-029 Macro DIV_SHARE_ARB_ZERO_CHECK_EN defined: denom==0 SHALL yield quot all-ones, rem=numer, resp_dz=1, with the same latency as a normal op.
REQ-030 Macro undefined: denom==0 passes to the division instance unchanged and resp_dz SHALL be tied 0.

Structure
REQ-031 Package div_share_arb_pkg SHALL hold default W and N_REQ constants, the tag width function (clog2 of N_REQ, min 1), the pipeline entry struct (valid, tag, quot, rem, dz) and the all-ones zero-divide constant.
REQ-032 Round-robin grant logic SHALL be sub-module div_rr_arbiter; the existing combinational division block SHALL be instantiated once.

Verification
REQ-033 Requester 0 only, 20/5, resp_ready=1 -> resp_quot[0]=4, rem=0, dz=0, resp_valid[0] exactly 3 edges after the accept (DIV_LAT=2).
REQ-034 All four requesters valid together -> accepts on consecutive cycles in order 0,1,2,3; results 100/7=14 r2, 65535/255=257 r0, 9/10=0 r9, 1/1=1 r0 arrive in that order.
REQ-035 Last grant 1, then requesters 0 and 3 valid -> grant 3 first, then 0.
REQ-036 Requester 2 issues 7/0 -> with the macro: quot=16'hFFFF, rem=7, dz=1; without it: dz=0.
REQ-037 resp_ready[1]=0 for 10 cycles after a result -> result held stable, req_ready[1]=0 while req_valid[1]=1; re-grant the cycle after the consume edge.
REQ-038 rst_n pulsed low with 2 ops in flight -> no resp_valid after release; busy=0; next grant goes to requester 0.
